// File: rtl/eth_pkg.sv
// Shared Ethernet receive/transmit definitions: FSM encoding, framing dibits, CRC-32 constants.
// No logic, no latency, no flow control.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

    localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0]  SFD_DIBIT      = 2'b11;
    localparam logic [31:0] CRC_POLY_REFL  = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB20E3;

endpackage

// File: rtl/eth_crc32_d8.sv
// Reflected CRC-32 next-state for one byte, shared by the RMII sender and receiver.
// Purely combinational; no flow control.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_w;

    always_comb begin
        crc_w = crc_i;
        for (int i = 0; i < 8; i++) begin
            crc_w = (crc_w >> 1) ^ (((crc_w[0] ^ data_i[i]) == 1'b1) ? CRC_POLY_REFL : 32'h0);
        end
        crc_o = crc_w;
    end

endmodule

// File: rtl/rmii_receiver.sv
// RMII receive path: strips preamble/SFD, assembles bytes, gives a per-frame good/bad verdict.
// Byte strobe 1 cycle after its last dibit, eof 1 cycle after crs_dv falls; no backpressure.
// FCS residue checking is present only when RMII_RX_CRC_CHECK_EN is defined.
module rmii_receiver
    import eth_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int MIN_FRAME_BYTES = 64,
    parameter int PRE_MIN_DIBITS  = 8
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        crs_dv,
    input  logic [1:0]  rx_d,
    input  logic        rx_er,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_good,
    output logic        rx_bad,
    output logic [10:0] byte_cnt
);

    localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME_BYTES);
    localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME_BYTES);
    localparam logic [7:0]  PRE_MIN = 8'(PRE_MIN_DIBITS);

    rx_state_e   state_q, state_d;
    logic [7:0]  pre_cnt_q, pre_cnt_d;
    logic [1:0]  dibit_cnt_q, dibit_cnt_d;
    logic [5:0]  shift_q, shift_d;
    logic        err_q, err_d;
    logic        seen_idle_q, seen_idle_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_sof_q, rx_sof_d;
    logic        rx_eof_q, rx_eof_d;
    logic        rx_good_q, rx_good_d;
    logic        rx_bad_q, rx_bad_d;
    logic [7:0]  asm_byte;
    logic        byte_done;
    logic        sfd_ok;
    logic        crc_ok;

    assign asm_byte  = {rx_d, shift_q};
    assign byte_done = (state_q == ST_DATA) && crs_dv && (dibit_cnt_q == 2'd3);
    assign sfd_ok    = crs_dv && (rx_d == SFD_DIBIT) && (pre_cnt_q >= PRE_MIN);

`ifdef RMII_RX_CRC_CHECK_EN
    logic [31:0] crc_q, crc_d, crc_nxt;

    eth_crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (asm_byte),
        .crc_o  (crc_nxt)
    );

    assign crc_ok = (crc_q == CRC_RESIDUE);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) crc_q <= CRC_INIT;
        else     crc_q <= crc_d;
    end
`else
    assign crc_ok = 1'b1;
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Only a carrier-off period arms preamble detection, so a reset mid-frame never resyncs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (crs_dv) state_d = (seen_idle_q && rx_d == PREAMBLE_DIBIT) ? ST_PREAMBLE : ST_DROP;
            end
            ST_PREAMBLE: begin
                if (!crs_dv)                     state_d = ST_IDLE;
                else if (sfd_ok)                 state_d = ST_DATA;
                else if (rx_d != PREAMBLE_DIBIT) state_d = ST_DROP;
            end
            ST_DATA: begin
                if (!crs_dv)                               state_d = ST_IDLE;
                else if (byte_done && byte_cnt_q == MAX_CNT) state_d = ST_DROP;
            end
            default: begin
                if (!crs_dv) state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        pre_cnt_d   = pre_cnt_q;
        dibit_cnt_d = dibit_cnt_q;
        shift_d     = shift_q;
        err_d       = err_q;
        seen_idle_d = seen_idle_q | ~crs_dv;
        byte_cnt_d  = byte_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_sof_d    = 1'b0;
        rx_eof_d    = 1'b0;
        rx_good_d   = 1'b0;
        rx_bad_d    = 1'b0;
`ifdef RMII_RX_CRC_CHECK_EN
        crc_d       = crc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (crs_dv && rx_d == PREAMBLE_DIBIT) pre_cnt_d = 8'd1;
            end
            ST_PREAMBLE: begin
                if (crs_dv && rx_d == PREAMBLE_DIBIT && pre_cnt_q != 8'hFF) pre_cnt_d = pre_cnt_q + 8'd1;
                if (sfd_ok) begin
                    dibit_cnt_d = 2'd0;
                    byte_cnt_d  = 11'd0;
                    err_d       = 1'b0;
`ifdef RMII_RX_CRC_CHECK_EN
                    crc_d       = CRC_INIT;
`endif
                end
            end
            ST_DATA: begin
                if (crs_dv) begin
                    shift_d     = asm_byte[7:2];
                    dibit_cnt_d = dibit_cnt_q + 2'd1;
                    if (rx_er) err_d = 1'b1;
                    if (byte_done) begin
                        if (byte_cnt_q == MAX_CNT) begin
                            rx_eof_d = 1'b1;
                            rx_bad_d = 1'b1;
                        end else begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = asm_byte;
                            rx_sof_d   = (byte_cnt_q == 11'd0);
                            byte_cnt_d = byte_cnt_q + 11'd1;
`ifdef RMII_RX_CRC_CHECK_EN
                            crc_d      = crc_nxt;
`endif
                        end
                    end
                end else begin
                    rx_eof_d  = 1'b1;
                    rx_bad_d  = err_q || (dibit_cnt_q != 2'd0) || (byte_cnt_q < MIN_CNT) || !crc_ok;
                    rx_good_d = !rx_bad_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q   <= 8'd0;
            dibit_cnt_q <= 2'd0;
            shift_q     <= 6'd0;
            err_q       <= 1'b0;
            seen_idle_q <= 1'b0;
            byte_cnt_q  <= 11'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            rx_sof_q    <= 1'b0;
            rx_eof_q    <= 1'b0;
            rx_good_q   <= 1'b0;
            rx_bad_q    <= 1'b0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            dibit_cnt_q <= dibit_cnt_d;
            shift_q     <= shift_d;
            err_q       <= err_d;
            seen_idle_q <= seen_idle_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_sof_q    <= rx_sof_d;
            rx_eof_q    <= rx_eof_d;
            rx_good_q   <= rx_good_d;
            rx_bad_q    <= rx_bad_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_sof   = rx_sof_q;
    assign rx_eof   = rx_eof_q;
    assign rx_good  = rx_good_q;
    assign rx_bad   = rx_bad_q;
    assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_rmii_receiver.sv
// Bench for rmii_receiver: directed and random frames scored against a frame-level model.
`timescale 1ns/1ps
module tb_rmii_receiver;

    localparam int MAXB   = 1518;
    localparam int MINB   = 64;
    localparam int PREMIN = 8;

    logic        sys_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        crs_dv  = 1'b0;
    logic [1:0]  rx_d    = 2'b00;
    logic        rx_er   = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_good, rx_bad;
    logic [10:0] byte_cnt;

    rmii_receiver dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .crs_dv   (crs_dv),
        .rx_d     (rx_d),
        .rx_er    (rx_er),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_sof   (rx_sof),
        .rx_eof   (rx_eof),
        .rx_good  (rx_good),
        .rx_bad   (rx_bad),
        .byte_cnt (byte_cnt)
    );

    always #10 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    logic [7:0]  tx_bytes[$];
    logic [7:0]  got_bytes[$], exp_bytes[$];
    int          got_sof[$], exp_sof[$];
    int          got_sofpos[$], exp_sofpos[$];
    logic [1:0]  got_eof[$], exp_eof[$];
    int          anomalies = 0;
    int          exp_cnt = 0;
    int          drv_sof_cyc = -1;
    logic [31:0] crc_tab[256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge sys_clk) begin
        if (rx_valid) got_bytes.push_back(rx_data);
        if (rx_sof) begin
            got_sof.push_back(cyc);
            got_sofpos.push_back(got_bytes.size() - 1);
        end
        if (rx_eof) got_eof.push_back({rx_good, rx_bad});
        if ((rx_eof && rx_valid) || (rx_eof && rx_good == rx_bad) ||
            (!rx_eof && (rx_good || rx_bad)) || (rx_sof && !rx_valid))
            anomalies++;
    end

    function automatic logic [31:0] tab_entry(input int i);
        logic [31:0] c;
        c = 32'(i);
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // FCS of the first n bytes of tx_bytes, table-driven
    function automatic logic [31:0] fcs_over(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) c = (c >> 8) ^ crc_tab[c[7:0] ^ tx_bytes[i]];
        return ~c;
    endfunction

    task automatic load_seq(input int n);
        tx_bytes.delete();
        for (int i = 0; i < n; i++) tx_bytes.push_back(8'(i));
    endtask

    task automatic load_rand(input int n);
        tx_bytes.delete();
        for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
    endtask

    task automatic append_fcs();
        logic [31:0] f;
        f = fcs_over(tx_bytes.size());
        tx_bytes.push_back(f[7:0]);
        tx_bytes.push_back(f[15:8]);
        tx_bytes.push_back(f[23:16]);
        tx_bytes.push_back(f[31:24]);
    endtask

    task automatic drive_frame(input int pre_len, input int n_extra, input int er_dibit,
                               input int gap, input bit idle_er, input int rst_dibit);
        logic [1:0] d[$];
        logic [7:0] b;
        for (int i = 0; i < pre_len; i++) d.push_back(2'b01);
        d.push_back(2'b11);
        foreach (tx_bytes[i]) begin
            b = tx_bytes[i];
            for (int k = 0; k < 4; k++) d.push_back(b[2*k +: 2]);
        end
        for (int i = 0; i < n_extra; i++) d.push_back(2'($urandom_range(0, 3)));
        drv_sof_cyc = -1;
        foreach (d[i]) begin
            @(posedge sys_clk); #1;
            crs_dv = 1'b1;
            rx_d   = d[i];
            rx_er  = (i == er_dibit);
            if (i == pre_len + 4) drv_sof_cyc = cyc + 1;
            if (rst_dibit >= 0 && i == rst_dibit) begin
                rst = 1'b1;
                #1;
                check("rst_mid_flags", 32'({rx_valid, rx_sof, rx_eof, rx_good, rx_bad}), 32'd0);
                check("rst_mid_cnt", 32'(byte_cnt), 32'd0);
                check("rst_mid_data", 32'(rx_data), 32'd0);
            end
            if (rst_dibit >= 0 && i == rst_dibit + 3) rst = 1'b0;
        end
        for (int i = 0; i < gap; i++) begin
            @(posedge sys_clk); #1;
            crs_dv = 1'b0;
            rx_er  = idle_er;
            rx_d   = 2'($urandom_range(0, 3));
        end
    endtask

    // Expected outcome of the frame in tx_bytes, from the framing and verdict rules
    task automatic model_frame(input int pre_len, input int n_extra, input int er_dibit);
        int   n, n_del;
        logic bad;
`ifdef RMII_RX_CRC_CHECK_EN
        logic [31:0] f;
`endif
        n = tx_bytes.size();
        if (pre_len < PREMIN) return;
        n_del = (n > MAXB) ? MAXB : n;
        if (n_del > 0) begin
            exp_sof.push_back(drv_sof_cyc);
            exp_sofpos.push_back(exp_bytes.size());
        end
        for (int i = 0; i < n_del; i++) exp_bytes.push_back(tx_bytes[i]);
        exp_cnt = n_del;
        if (n > MAXB) begin
            exp_eof.push_back(2'b01);
            return;
        end
        bad = (n < MINB) || (n_extra != 0) ||
              (er_dibit > pre_len && er_dibit < pre_len + 1 + 4*n + n_extra);
`ifdef RMII_RX_CRC_CHECK_EN
        if (n < 4) bad = 1'b1;
        else begin
            f = fcs_over(n - 4);
            if ({tx_bytes[n-1], tx_bytes[n-2], tx_bytes[n-3], tx_bytes[n-4]} != f) bad = 1'b1;
        end
`endif
        exp_eof.push_back(bad ? 2'b01 : 2'b10);
    endtask

    task automatic checkpoint(input string tag);
        int n;
        repeat (4) begin
            @(posedge sys_clk); #1;
            crs_dv = 1'b0;
            rx_er  = 1'b0;
        end
        @(negedge sys_clk); #1;
        check({tag, ":nbytes"}, 32'(got_bytes.size()), 32'(exp_bytes.size()));
        n = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
        for (int i = 0; i < n; i++) check({tag, ":byte"}, 32'(got_bytes[i]), 32'(exp_bytes[i]));
        check({tag, ":nsof"}, 32'(got_sof.size()), 32'(exp_sof.size()));
        n = (got_sof.size() < exp_sof.size()) ? got_sof.size() : exp_sof.size();
        for (int i = 0; i < n; i++) begin
            check({tag, ":sof_cycle"}, 32'(got_sof[i]), 32'(exp_sof[i]));
            check({tag, ":sof_pos"}, 32'(got_sofpos[i]), 32'(exp_sofpos[i]));
        end
        check({tag, ":neof"}, 32'(got_eof.size()), 32'(exp_eof.size()));
        n = (got_eof.size() < exp_eof.size()) ? got_eof.size() : exp_eof.size();
        for (int i = 0; i < n; i++) check({tag, ":verdict_gb"}, 32'(got_eof[i]), 32'(exp_eof[i]));
        check({tag, ":strobe_rules"}, 32'(anomalies), 32'd0);
        check({tag, ":byte_cnt"}, 32'(byte_cnt), 32'(exp_cnt));
        got_bytes.delete(); exp_bytes.delete();
        got_sof.delete();   exp_sof.delete();
        got_sofpos.delete(); exp_sofpos.delete();
        got_eof.delete();   exp_eof.delete();
        anomalies = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int pre, ext, er, gap, nd, idx;
        logic [7:0] m;
        for (int i = 0; i < 256; i++) crc_tab[i] = tab_entry(i);

        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_flags", 32'({rx_valid, rx_sof, rx_eof, rx_good, rx_bad}), 32'd0);
        check("reset_data", 32'(rx_data), 32'd0);
        check("reset_cnt", 32'(byte_cnt), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("post_reset_flags", 32'({rx_valid, rx_sof, rx_eof, rx_good, rx_bad}), 32'd0);

        load_seq(60); append_fcs();
        drive_frame(28, 0, -1, 2, 1'b0, -1); model_frame(28, 0, -1);
        checkpoint("good");

        load_seq(60); append_fcs(); tx_bytes[10] = 8'hFF;
        drive_frame(28, 0, -1, 2, 1'b0, -1); model_frame(28, 0, -1);
        checkpoint("corrupt");

        load_seq(60); append_fcs();
        drive_frame(28, 0, 28 + 1 + 4*30 + 1, 3, 1'b1, -1); model_frame(28, 0, 28 + 1 + 4*30 + 1);
        load_rand(60); append_fcs();
        drive_frame(10, 0, -1, 1, 1'b1, -1); model_frame(10, 0, -1);
        checkpoint("rx_er");

        load_rand(36); append_fcs();
        drive_frame(12, 0, -1, 2, 1'b0, -1); model_frame(12, 0, -1);
        checkpoint("runt");

        load_seq(60); append_fcs();
        drive_frame(12, 2, -1, 2, 1'b0, -1); model_frame(12, 2, -1);
        checkpoint("misaligned");

        load_rand(1600);
        drive_frame(9, 0, -1, 2, 1'b0, -1); model_frame(9, 0, -1);
        checkpoint("oversize");

        load_seq(60); append_fcs();
        drive_frame(4, 0, -1, 2, 1'b0, -1); model_frame(4, 0, -1);
        checkpoint("short_pre");

        load_seq(60); append_fcs();
        drive_frame(28, 0, -1, 2, 1'b0, 28 + 1 + 82);
        exp_sof.push_back(drv_sof_cyc);
        exp_sofpos.push_back(exp_bytes.size());
        for (int i = 0; i < 20; i++) exp_bytes.push_back(tx_bytes[i]);
        exp_cnt = 0;
        checkpoint("reset_mid");
        load_rand(60); append_fcs();
        drive_frame(16, 0, -1, 2, 1'b0, -1); model_frame(16, 0, -1);
        checkpoint("after_reset");

        for (int g = 0; g < 5; g++) begin
            for (int f = 0; f < 3; f++) begin
                nd = $urandom_range(20, 110);
                load_rand(nd); append_fcs();
                if ($urandom_range(0, 3) == 0) begin
                    idx = $urandom_range(0, nd + 3);
                    m = 8'h01 << $urandom_range(0, 7);
                    tx_bytes[idx] = tx_bytes[idx] ^ m;
                end
                pre = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 31);
                ext = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                er  = ($urandom_range(0, 4) == 0) ? pre + 1 + $urandom_range(0, 4*(nd + 4) + ext - 1) : -1;
                gap = $urandom_range(1, 4);
                drive_frame(pre, ext, er, gap, 1'($urandom_range(0, 1)), -1);
                model_frame(pre, ext, er);
            end
            checkpoint("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
